// File: rtl/identificador_param.sv
// Programmable serial pattern detector: masked compare of the last `len` valid
// bits against `refe`, with overlap control and a saturating match counter.

module identificador_bit (
  input  logic active,
  input  logic care,
  input  logic ref_bit,
  input  logic win_bit,
  output logic hit
);
  assign hit = !active || !care || (ref_bit == win_bit);
endmodule

module identificador_param #(
  parameter int SEQ_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(SEQ_W+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in,
  input  logic [SEQ_W-1:0] refe,
  input  logic [SEQ_W-1:0] mask,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             flag,
  output logic [CNT_W-1:0] match_count
);
  localparam int LW1 = LEN_W + 1;
  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(SEQ_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SEQ_W-1:0] window, next_window, active, hit;
  logic [LEN_W-1:0] fill;
  logic             len_ok, fill_ok, match;

  assign next_window = {window[SEQ_W-2:0], in};

  for (genvar i = 0; i < SEQ_W; i++) begin : g_bit
    assign active[i] = LW1'(i) < {1'b0, len};
    identificador_bit u_bit (
      .active (active[i]),
      .care   (mask[i]),
      .ref_bit(refe[i]),
      .win_bit(next_window[i]),
      .hit    (hit[i])
    );
  end

  // fill counts bits already held; the incoming bit makes fill+1 available
  assign len_ok  = (len != '0) && (len <= MAX_FILL);
  assign fill_ok = ({1'b0, fill} + LW1'(1)) >= {1'b0, len};
  assign match   = in_valid && len_ok && fill_ok && (&hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window      <= '0;
      fill        <= '0;
      flag        <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      window      <= '0;
      fill        <= '0;
      flag        <= 1'b0;
      match_count <= '0;
    end else begin
      flag <= match;
      if (in_valid) begin
        window <= next_window;
        if (match && !overlap)     fill <= '0;
        else if (fill != MAX_FILL) fill <= fill + LEN_W'(1);
        if (match && match_count != CNT_MAX) match_count <= match_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_identificador_param.sv
// Bench for identificador_param: directed scenarios plus randomized traffic
// checked against a bit-history reference model.

module tb_identificador_param;
  localparam int SEQ_W = 8;
  localparam int CNT_W = 3;
  localparam int LEN_W = $clog2(SEQ_W+1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 0;
  logic             reset = 0;
  logic             clear = 0;
  logic             in_valid = 0;
  logic             in = 0;
  logic [SEQ_W-1:0] refe = '0;
  logic [SEQ_W-1:0] mask = '1;
  logic [LEN_W-1:0] len = '0;
  logic             overlap = 1;
  logic             flag;
  logic [CNT_W-1:0] match_count;

  identificador_param #(.SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
    .refe(refe), .mask(mask), .len(len), .overlap(overlap),
    .flag(flag), .match_count(match_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // reference state: received bits (newest at back), bits usable since last restart
  bit hist[$];
  int avail = 0;
  int m_cnt = 0;
  bit m_flag = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    avail  = 0;
    m_cnt  = 0;
    m_flag = 0;
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    bit hitm;
    in_valid = v; in = b; clear = c;
    m_flag = 0;
    if (c) model_clear();
    else if (v) begin
      hist.push_back(b);
      if (hist.size() > SEQ_W) void'(hist.pop_front());
      hitm = (int'(len) >= 1) && (int'(len) <= SEQ_W) && (avail + 1 >= int'(len));
      for (int j = 0; j < int'(len) && hitm; j++)
        if (mask[j] && (j >= hist.size() || hist[hist.size()-1-j] != refe[j])) hitm = 0;
      if (hitm) begin
        m_flag = 1;
        if (m_cnt < CMAX) m_cnt++;
        avail = overlap ? ((avail < SEQ_W) ? avail + 1 : SEQ_W) : 0;
      end else avail = (avail < SEQ_W) ? avail + 1 : SEQ_W;
    end
    @(posedge clk); #1;
    chk("flag", 32'(flag), 32'(m_flag));
    chk("count", 32'(match_count), 32'(m_cnt));
  endtask

  // feed n bits MSB first, all valid
  task automatic feed(input logic [15:0] bits, input int n);
    logic [15:0] bv;
    bv = bits;
    for (int k = n - 1; k >= 0; k--) step(1, bv[k], 0);
  endtask

  task automatic mid_reset();
    reset = 0;
    model_clear();
    #2;
    chk("async_rst_flag", 32'(flag), 32'd0);
    chk("async_rst_cnt", 32'(match_count), 32'd0);
    #2 reset = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #3;
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_cnt", 32'(match_count), 32'd0);
    @(posedge clk); #1 reset = 1;

    // overlapping 1011 on 1,0,1,1,0,1,1
    len = 4; refe = 8'b0000_1011; mask = '1; overlap = 1;
    feed(16'b101_1011, 7);
    chk("t1_cnt", 32'(match_count), 32'd2);

    step(0, 0, 1);
    overlap = 0;
    feed(16'b101_1011, 7);
    chk("t2_cnt", 32'(match_count), 32'd1);

    // masked middle bits
    step(0, 0, 1);
    overlap = 1; refe = 8'b0000_1001; mask = 8'b0000_1001;
    feed(16'b1111, 4);
    chk("t3a_cnt", 32'(match_count), 32'd1);
    step(0, 0, 1);
    feed(16'b1110, 4);
    chk("t3b_cnt", 32'(match_count), 32'd0);

    // gaps in in_valid
    step(0, 0, 1);
    refe = 8'b0000_1011; mask = '1;
    step(1, 1, 0); step(0, 0, 0); step(1, 0, 0); step(0, 1, 0);
    step(0, 0, 0); step(1, 1, 0); step(0, 0, 0); step(1, 1, 0);
    chk("t4_cnt", 32'(match_count), 32'd1);

    // len=0 never matches
    step(0, 0, 1);
    len = 0; mask = '0;
    for (int k = 0; k < 10; k++) step(1, 1'($urandom), 0);
    chk("t5_cnt", 32'(match_count), 32'd0);

    // counter saturation
    step(0, 0, 1);
    len = 1; refe = 8'h01; mask = '1; overlap = 1;
    for (int k = 1; k <= 9; k++) begin
      step(1, 1, 0);
      chk("sat_cnt", 32'(match_count), 32'((k < CMAX) ? k : CMAX));
    end

    // reset mid-pattern
    step(0, 0, 1);
    len = 4; refe = 8'b0000_1011;
    feed(16'b101, 3);
    mid_reset();
    step(1, 1, 0);
    chk("post_rst_first", 32'(flag), 32'd0);
    feed(16'b011, 3);
    chk("post_rst_cnt", 32'(match_count), 32'd1);

    // clear coincident with the completing bit
    step(0, 0, 1);
    feed(16'b101, 3);
    step(1, 1, 1);
    chk("clr_coinc_cnt", 32'(match_count), 32'd0);

    // randomized traffic with mid-stream reconfiguration
    for (int n = 0; n < 800; n++) begin
      if (n % 25 == 0) begin
        len     = LEN_W'($urandom_range(0, 10));
        refe    = SEQ_W'($urandom);
        mask    = ($urandom_range(0, 3) == 0) ? '0 : SEQ_W'($urandom | $urandom);
        overlap = 1'($urandom);
      end
      if ($urandom_range(0, 150) == 0) mid_reset();
      else step(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom_range(0, 60) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
